usb_hid_kbd_events: RTL

Downstream consumer of the USB HID host report. Takes each boot-protocol keyboard report (modifier byte, reserved byte, six keycodes) and diffs it against the previous accepted report. Emits one press or release event per changed key into a FWFT FIFO that the SoC CPU drains over a valid/ready interface. Sits inside the SoC clock domain, between the usb_report_i/usb_report_valid_i inputs and the CPU peripheral bus.

---
 rtl/usb_hid_pkg.sv | 78 +++++++
 rtl/usb_event_fifo.sv | 52 +++++
 rtl/usb_hid_kbd_events.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_hid_pkg.sv
// Shared types and helpers for the HID keyboard report diff engine.
// Report layout, event format, scan states and key-set membership checks.
package usb_hid_pkg;

  localparam logic [7:0] KEY_NONE         = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] MOD_USAGE_BASE   = 8'hE0;
  localparam int unsigned KBD_NB_KEYS     = 6;

  typedef struct packed {
    logic [7:0]                  mod;
    logic [7:0]                  rsvd;
    logic [KBD_NB_KEYS-1:0][7:0] key;
  } kbd_report_t;

  typedef struct packed {
    logic       pressed;
    logic [7:0] usage;
  } kbd_event_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_MOD,
    SCAN_REL,
    SCAN_PRS,
    COMMIT
  } scan_state_e;

  function automatic kbd_report_t unpack_report(input logic [63:0] raw);
    kbd_report_t r;
    r.mod  = raw[7:0];
    r.rsvd = raw[15:8];
    for (int i = 0; i < KBD_NB_KEYS; i++) begin
      r.key[i] = raw[8*i+16 +: 8];
    end
    return r;
  endfunction

  function automatic logic is_phantom(input kbd_report_t r);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < KBD_NB_KEYS; i++) begin
      if (r.key[i] == KEY_ERR_ROLLOVER) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic key_listed(input logic [7:0]                  k,
                                      input logic [KBD_NB_KEYS-1:0][7:0] keys);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < KBD_NB_KEYS; i++) begin
      if (keys[i] == k) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when k already appeared at a lower index of its own report.
  function automatic logic key_seen_before(input logic [7:0]                  k,
                                           input logic [KBD_NB_KEYS-1:0][7:0] keys,
                                           input logic [2:0]                  upto);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < KBD_NB_KEYS; j++) begin
      if (j < int'(upto) && keys[j] == k) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic key_changed(input logic [7:0]                  k,
                                       input logic [KBD_NB_KEYS-1:0][7:0] other,
                                       input logic [KBD_NB_KEYS-1:0][7:0] own,
                                       input logic [2:0]                  idx);
    return (k != KEY_NONE) && (k != KEY_ERR_ROLLOVER) && !key_listed(k, other) &&
           !key_seen_before(k, own, idx);
  endfunction

endpackage

// File: rtl/usb_event_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever valid is high.
// Push while full is accepted only when a pop happens in the same cycle.
module usb_event_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign valid    = count_q != '0;
  assign full     = count_q == (PtrW+1)'(Depth);
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/usb_hid_kbd_events.sv
// Diffs successive boot-protocol keyboard reports and queues one press/release event
// per changed modifier or key for the CPU, with a single-deep pending report slot.
module usb_hid_kbd_events
  import usb_hid_pkg::*;
#(
  parameter int unsigned REPORT_NB_BYTES = 8,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic [REPORT_NB_BYTES*8-1:0] usb_report_i,
  input  logic                         usb_report_valid_i,
  output logic [8:0]                   event_o,
  output logic                         event_valid_o,
  input  logic                         event_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  input  logic                         overrun_clear_i
);

  scan_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  kbd_report_t cur_q, cur_d, prev_q, prev_d, pend_q, pend_d, rx_report;
  logic        pend_valid_q, pend_valid_d;
  logic        overrun_q, overrun_d;
  logic        pend_take, direct_cap, overrun_set;
  logic        phantom, cand_valid, last_idx, stall, push, pop, fifo_full;
  kbd_event_t  cand;
  logic [7:0]  rel_key, prs_key;
  logic        unused_bits;

  assign rx_report   = unpack_report(usb_report_i[63:0]);
  assign rel_key     = prev_q.key[idx_q];
  assign prs_key     = cur_q.key[idx_q];
  assign phantom     = is_phantom(cur_q);
  assign unused_bits = ^{prev_q.rsvd, usb_report_i};

  // Candidate event for the current scan index.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    last_idx   = 1'b0;
    case (state_q)
      SCAN_MOD: begin
        cand.pressed = cur_q.mod[idx_q];
        cand.usage   = MOD_USAGE_BASE + {5'd0, idx_q};
        cand_valid   = !phantom && (cur_q.mod[idx_q] != prev_q.mod[idx_q]);
        last_idx     = idx_q == 3'd7;
      end
      SCAN_REL: begin
        cand       = {1'b0, rel_key};
        cand_valid = key_changed(rel_key, cur_q.key, prev_q.key, idx_q);
        last_idx   = idx_q == 3'd5;
      end
      SCAN_PRS: begin
        cand       = {1'b1, prs_key};
        cand_valid = key_changed(prs_key, prev_q.key, cur_q.key, idx_q);
        last_idx   = idx_q == 3'd5;
      end
      default: ;
    endcase
  end

  assign pop   = event_valid_o && event_ready_i;
  assign stall = cand_valid && fifo_full && !pop;
  assign push  = cand_valid && !stall;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    pend_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          cur_d     = pend_q;
          pend_take = 1'b1;
          state_d   = SCAN_MOD;
          idx_d     = '0;
        end else if (usb_report_valid_i) begin
          cur_d   = rx_report;
          state_d = SCAN_MOD;
          idx_d   = '0;
        end
      end
      SCAN_MOD: begin
        if (phantom) begin
          // Rollover report: prev stays as is, move on to whatever is pending.
          if (pend_valid_q) begin
            cur_d     = pend_q;
            pend_take = 1'b1;
            idx_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (!stall) begin
          if (last_idx) begin
            state_d = SCAN_REL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      SCAN_REL: begin
        if (!stall) begin
          if (last_idx) begin
            state_d = SCAN_PRS;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      SCAN_PRS: begin
        if (!stall) begin
          if (last_idx) begin
            state_d = COMMIT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        prev_d = cur_q;
        if (pend_valid_q) begin
          cur_d     = pend_q;
          pend_take = 1'b1;
          state_d   = SCAN_MOD;
          idx_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign direct_cap = usb_report_valid_i && (state_q == IDLE) && !pend_valid_q;

  // A slot being drained this cycle can take a new report without losing anything.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overrun_set  = 1'b0;
    if (pend_take) pend_valid_d = 1'b0;
    if (usb_report_valid_i && !direct_cap) begin
      pend_d       = rx_report;
      pend_valid_d = 1'b1;
      overrun_set  = pend_valid_q && !pend_take;
    end
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clear_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cur_q        <= '0;
      prev_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  usb_event_fifo #(
    .Width(9),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset_i),
    .push     (push),
    .push_data(cand),
    .pop      (pop),
    .pop_data (event_o),
    .valid    (event_valid_o),
    .full     (fifo_full),
    .count    (fifo_count_o)
  );

  assign busy_o    = state_q != IDLE;
  assign overrun_o = overrun_q;

endmodule
